// File: rtl/float_writeback_arbiter.sv
// Float register-file write-port producer: per-unit result queues serialised round-robin
// onto one registered write port, plus a 32-entry pending-write scoreboard.

module fwb_src_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head,
  output logic         ready,
  output logic         nonempty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;

  // ready comes from the registered count, so a full queue refuses even while popping
  assign ready    = cnt_q != (AW+1)'(DEPTH);
  assign nonempty = cnt_q != '0;
  assign head     = mem_q[rp_q];

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wp_q] = push_data;
      wp_d        = wp_q + 1'b1;
    end
    if (pop) rp_d = rp_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

module float_writeback_arbiter #(
  parameter int NSRC  = 3,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clken,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  output logic                 waw_hazard,
  input  logic [NSRC-1:0]      src_valid,
  input  logic [5*NSRC-1:0]    src_rd,
  input  logic [32*NSRC-1:0]   src_data,
  output logic [NSRC-1:0]      src_ready,
  output logic [4:0]           rdi,
  output logic [31:0]          write_data,
  output logic                 reg_write,
  output logic [31:0]          busy
);
  localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t [NSRC-1:0] head;
  wb_ent_t            gnt_ent;
  logic [NSRC-1:0]    push, pop, nonempty;
  logic [SW-1:0]      rr_q, rr_d, gnt_idx;
  logic               gnt_vld;
  logic               reg_write_q, reg_write_d;
  logic [4:0]         rdi_q, rdi_d;
  logic [31:0]        write_data_q, write_data_d;
  logic [31:0]        busy_q, busy_d;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign push[i] = clken & src_valid[i] & src_ready[i];
    assign pop[i]  = clken & gnt_vld & (gnt_idx == SW'(i));
    fwb_src_queue #(.DEPTH(DEPTH), .W($bits(wb_ent_t))) u_q (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .pop       (pop[i]),
      .push_data ({src_rd[5*i +: 5], src_data[32*i +: 32]}),
      .head      (head[i]),
      .ready     (src_ready[i]),
      .nonempty  (nonempty[i])
    );
  end

  // first non-empty queue searching upward from rr+1
  always_comb begin
    int j;
    gnt_vld = 1'b0;
    gnt_idx = rr_q;
    for (int k = 1; k <= NSRC; k++) begin
      j = (int'(rr_q) + k) % NSRC;
      if (!gnt_vld && nonempty[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = SW'(j);
      end
    end
  end

  assign gnt_ent    = head[gnt_idx];
  assign waw_hazard = issue_valid & busy_q[issue_rd];

  always_comb begin
    rr_d         = gnt_vld ? gnt_idx : rr_q;
    reg_write_d  = gnt_vld;
    rdi_d        = gnt_vld ? gnt_ent.rd : rdi_q;
    write_data_d = gnt_vld ? gnt_ent.data : write_data_q;
    busy_d       = busy_q;
    // clear before set so a same-edge issue to the retiring register stays busy
    if (gnt_vld) busy_d[gnt_ent.rd] = 1'b0;
    if (issue_valid && !waw_hazard) busy_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q         <= SW'(NSRC - 1);
      reg_write_q  <= 1'b0;
      rdi_q        <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
    end else if (clken) begin
      rr_q         <= rr_d;
      reg_write_q  <= reg_write_d;
      rdi_q        <= rdi_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign rdi        = rdi_q;
  assign write_data = write_data_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_float_writeback_arbiter.sv
// Directed + randomized bench for float_writeback_arbiter against a queue-based
// behavioural model of the write-back path and scoreboard.
module tb_float_writeback_arbiter;
  localparam int NSRC  = 3;
  localparam int DEPTH = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                clken = 1'b1;
  logic                issue_valid = 1'b0;
  logic [4:0]          issue_rd = '0;
  logic                waw_hazard;
  logic [NSRC-1:0]     src_valid = '0;
  logic [NSRC-1:0]     src_ready;
  logic [5*NSRC-1:0]   src_rd = '0;
  logic [32*NSRC-1:0]  src_data = '0;
  logic [4:0]          rdi;
  logic [31:0]         write_data;
  logic                reg_write;
  logic [31:0]         busy;

  int checks = 0, failures = 0, writes_obs = 0, accepts = 0;

  // reference model: plain per-source FIFOs of {rd,data}
  logic [36:0]     mq [NSRC][$];
  int              m_rr;
  logic [31:0]     m_busy;
  logic            m_rw;
  logic [4:0]      m_rdi;
  logic [31:0]     m_wd;
  logic [NSRC-1:0] last_acc;
  logic            saw_not_ready;

  always #5 clk = ~clk;

  float_writeback_arbiter #(.NSRC(NSRC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clken(clken), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .waw_hazard(waw_hazard), .src_valid(src_valid), .src_rd(src_rd), .src_data(src_data),
    .src_ready(src_ready), .rdi(rdi), .write_data(write_data), .reg_write(reg_write), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NSRC; i++) mq[i].delete();
    m_rr = NSRC - 1; m_busy = '0; m_rw = 1'b0; m_rdi = '0; m_wd = '0; last_acc = '0;
  endtask

  task automatic set_src(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
    src_valid[i]       = v;
    src_rd[5*i +: 5]   = rd;
    src_data[32*i +: 32] = d;
  endtask

  // one clock: check combinational outputs, advance model, clock DUT, check registered outputs
  task automatic step();
    logic [NSRC-1:0] exp_ready, acc;
    logic [36:0]     ent;
    logic            haz, en;
    int              g;
    #1;
    for (int i = 0; i < NSRC; i++) exp_ready[i] = (mq[i].size() < DEPTH);
    haz = issue_valid && m_busy[issue_rd];
    chk("src_ready", 64'(src_ready), 64'(exp_ready));
    chk("waw_hazard", 64'(waw_hazard), 64'(haz));
    if (src_ready != {NSRC{1'b1}}) saw_not_ready = 1'b1;
    en  = clken;
    acc = '0;
    if (en) begin
      acc = src_valid & exp_ready;
      g = -1;
      for (int k = 1; k <= NSRC; k++) begin
        int j;
        j = (m_rr + k) % NSRC;
        if (g < 0 && mq[j].size() > 0) g = j;
      end
      if (g >= 0) begin
        ent = mq[g].pop_front();
        m_rdi = ent[36:32]; m_wd = ent[31:0]; m_rw = 1'b1; m_rr = g;
        m_busy[m_rdi] = 1'b0;
      end else m_rw = 1'b0;
      if (issue_valid && !haz) m_busy[issue_rd] = 1'b1;
      for (int i = 0; i < NSRC; i++)
        if (acc[i]) begin
          mq[i].push_back({src_rd[5*i +: 5], src_data[32*i +: 32]});
          accepts++;
        end
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    if (en && reg_write) writes_obs++;
    chk("reg_write", 64'(reg_write), 64'(m_rw));
    chk("rdi", 64'(rdi), 64'(m_rdi));
    chk("write_data", 64'(write_data), 64'(m_wd));
    chk("busy", 64'(busy), 64'(m_busy));
  endtask

  task automatic drain();
    int n;
    logic empty;
    src_valid = '0; issue_valid = 1'b0; clken = 1'b1;
    n = 0;
    empty = 1'b0;
    while (!empty && n < 40) begin
      empty = 1'b1;
      for (int i = 0; i < NSRC; i++) if (mq[i].size() != 0) empty = 1'b0;
      if (!empty) step();
      n++;
    end
    step();
    chk("drain_bound", 64'(empty), 64'(1));
  endtask

  initial begin
    logic [31:0] frz_wd;
    logic [4:0]  frz_rdi;
    logic        frz_rw;
    int          seq;
    model_reset();
    saw_not_ready = 1'b0;
    seq = 0;

    // reset state
    #1;
    chk("rst_reg_write", 64'(reg_write), 64'(0));
    chk("rst_rdi", 64'(rdi), 64'(0));
    chk("rst_write_data", 64'(write_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_src_ready", 64'(src_ready), 64'({NSRC{1'b1}}));
    #11 rst = 1'b0;

    // issue rd=5, two cycles later src1 returns its result
    issue_valid = 1'b1; issue_rd = 5'd5;
    step();
    issue_valid = 1'b0;
    step();
    set_src(1, 1'b1, 5'd5, 32'h3F80_0000);
    step();
    chk("t2_busy5_pending", 64'(busy[5]), 64'(1));
    src_valid = '0;
    step();
    chk("t2_reg_write", 64'(reg_write), 64'(1));
    chk("t2_rdi", 64'(rdi), 64'(5));
    chk("t2_data", 64'(write_data), 64'(32'h3F80_0000));
    chk("t2_busy5_clear", 64'(busy[5]), 64'(0));

    // occupy queues then reset mid-cycle
    issue_valid = 1'b1; issue_rd = 5'd9;
    for (int i = 0; i < NSRC; i++) set_src(i, 1'b1, 5'(20 + i), 32'hDEAD_0000 + i);
    step();
    issue_valid = 1'b0;
    step();
    src_valid = '0;
    #3 rst = 1'b1;
    #1;
    chk("t1_reg_write", 64'(reg_write), 64'(0));
    chk("t1_busy", 64'(busy), 64'(0));
    chk("t1_src_ready", 64'(src_ready), 64'({NSRC{1'b1}}));
    model_reset();
    #2 rst = 1'b0;
    for (int n = 0; n < 4; n++) step();

    // simultaneous arrivals are written 1,2,3
    for (int i = 0; i < NSRC; i++) set_src(i, 1'b1, 5'(i + 1), 32'hA000_0000 + i);
    step();
    src_valid = '0;
    step(); chk("t3_first", 64'(rdi), 64'(1));
    step(); chk("t3_second", 64'(rdi), 64'(2));
    step(); chk("t3_third", 64'(rdi), 64'(3));
    // src0 and src2 streaming: grants alternate
    set_src(0, 1'b1, 5'd10, 32'hB000_0000);
    set_src(2, 1'b1, 5'd12, 32'hC000_0000);
    for (int n = 0; n < 10; n++) begin
      step();
      if (last_acc[0]) set_src(0, 1'b1, 5'd10, 32'hB000_0000 + n + 1);
      if (last_acc[2]) set_src(2, 1'b1, 5'd12, 32'hC000_0000 + n + 1);
    end
    drain();

    // all sources push every cycle for 10 cycles
    writes_obs = 0; accepts = 0; saw_not_ready = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      set_src(i, 1'b1, 5'($urandom_range(31)), {8'(i), 24'(seq)}); seq++;
    end
    for (int n = 0; n < 10; n++) begin
      step();
      for (int i = 0; i < NSRC; i++)
        if (last_acc[i]) begin
          set_src(i, 1'b1, 5'($urandom_range(31)), {8'(i), 24'(seq)}); seq++;
        end
    end
    drain();
    chk("t4_ready_dropped", 64'(saw_not_ready), 64'(1));
    chk("t4_writes_eq_accepts", 64'(writes_obs), 64'(accepts));

    // WAW hazard and same-edge set/clear
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    #1 chk("t5_waw_second", 64'(waw_hazard), 64'(1));
    step();
    chk("t5_busy7_held", 64'(busy[7]), 64'(1));
    issue_valid = 1'b0;
    set_src(0, 1'b1, 5'd7, 32'h1111_1111);
    step();
    src_valid = '0;
    step();
    chk("t5_busy7_cleared", 64'(busy[7]), 64'(0));
    set_src(0, 1'b1, 5'd7, 32'h2222_2222);
    step();
    src_valid = '0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    chk("t5_same_edge_rw", 64'(reg_write), 64'(1));
    chk("t5_same_edge_busy7", 64'(busy[7]), 64'(1));

    // clken stall mid-stream with src_valid held
    set_src(0, 1'b1, 5'd14, 32'hE000_0000);
    set_src(1, 1'b1, 5'd15, 32'hF000_0000);
    for (int n = 0; n < 3; n++) begin
      step();
      if (last_acc[0]) set_src(0, 1'b1, 5'd14, 32'hE000_0001 + n);
      if (last_acc[1]) set_src(1, 1'b1, 5'd15, 32'hF000_0001 + n);
    end
    frz_rw = reg_write; frz_rdi = rdi; frz_wd = write_data;
    clken = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("t6_frozen_rw", 64'(reg_write), 64'(frz_rw));
      chk("t6_frozen_rdi", 64'(rdi), 64'(frz_rdi));
      chk("t6_frozen_wd", 64'(write_data), 64'(frz_wd));
    end
    clken = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      if (last_acc[0]) set_src(0, 1'b1, 5'd14, 32'hE100_0000 + n);
      if (last_acc[1]) set_src(1, 1'b1, 5'd15, 32'hF100_0000 + n);
    end
    drain();

    // randomized traffic with stalls and hazards
    writes_obs = 0; accepts = 0;
    for (int n = 0; n < 400; n++) begin
      clken       = ($urandom_range(9) != 0);
      issue_valid = ($urandom_range(3) == 0);
      issue_rd    = 5'($urandom_range(7));
      step();
      for (int i = 0; i < NSRC; i++)
        if (last_acc[i] || !src_valid[i]) begin
          set_src(i, ($urandom_range(2) != 0), 5'($urandom_range(7)), $urandom());
        end
    end
    drain();
    chk("rand_writes_eq_accepts", 64'(writes_obs), 64'(accepts));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
